// File: rtl/video_scaler_pkg.sv
// Shared constants and types for the 3x video scalers (upscaler and downscaler).
package video_scaler_pkg;

  localparam int unsigned SCALE_FACTOR = 3;
  localparam logic [15:0] DIV9_MUL     = 16'd7282;
  localparam int unsigned DIV9_SHIFT   = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Reciprocal multiply; exact for multiples of 9 up to 9*255.
  function automatic logic [7:0] div9(input logic [11:0] total);
    logic [25:0] prod;
    prod = 26'(total) * 26'(DIV9_MUL);
    return prod[DIV9_SHIFT +: 8];
  endfunction

endpackage

// File: rtl/video_box3_line_acc.sv
// Line accumulator RAM: simple dual-port, one write port, registered read. Contents not reset.
module video_box3_line_acc #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/video_downscaler_3x.sv
// 3x3 -> 1 RGB888 downscaler. VIDEO_DOWNSCALER_BOX_FILTER_EN selects a 3x3 box average;
// without it each block is point-sampled at its top-left pixel.
module video_downscaler_3x
  import video_scaler_pkg::*;
#(
  parameter int unsigned NATIVE_WIDTH  = 320,
  parameter int unsigned NATIVE_HEIGHT = 224,
  localparam int unsigned XW = $clog2(NATIVE_WIDTH),
  localparam int unsigned YW = $clog2(NATIVE_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          de_in,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          valid_out,
  output logic          hs_out,
  output logic          vs_out
);

  localparam int unsigned NXW = $clog2(NATIVE_WIDTH + 1);
  localparam int unsigned NYW = $clog2(NATIVE_HEIGHT + 1);
  localparam logic [1:0]  LAST_PHASE = 2'(SCALE_FACTOR - 1);
`ifdef VIDEO_DOWNSCALER_BOX_FILTER_EN
  localparam int unsigned HW   = 10;
  localparam int unsigned ACCW = 12;
`else
  localparam int unsigned HW   = 8;
  localparam int unsigned ACCW = 8;
`endif

  logic                 de_q, vs_q1, vs_q2, hs_q1, hs_q2;
  logic [1:0]           px_q, px_c, px_d, py_q, py_c, py_d;
  logic [NXW-1:0]       nx_q, nx_c, nx_d;
  logic [NYW-1:0]       ny_q, ny_c, ny_d;
  logic                 vs_rise, take;
  logic [2:0][7:0]      pix, res;
  logic [2:0][HW-1:0]   hsum_q, hsum_d;
  logic [2:0][ACCW-1:0] rd_data, wr_data, total_q, total_d;
  logic                 rd_en, wr_en;
  logic                 s1_valid_q, s1_valid_d;
  logic [XW-1:0]        s1_x_q, x_q;
  logic [YW-1:0]        s1_y_q, y_q;
  logic                 valid_q;
  rgb_t                 out_q;

  assign pix     = {r_in, g_in, b_in};
  assign vs_rise = vs_in & ~vs_q1;

  // A vs rise overrides the registered counters so a coincident pixel lands at (0,0).
  always_comb begin
    px_c = vs_rise ? 2'd0 : px_q;
    py_c = vs_rise ? 2'd0 : py_q;
    nx_c = vs_rise ? '0 : nx_q;
    ny_c = vs_rise ? '0 : ny_q;
    px_d = px_c;
    py_d = py_c;
    nx_d = nx_c;
    ny_d = ny_c;
    if (de_in) begin
      if (px_c == LAST_PHASE) begin
        px_d = 2'd0;
        if (nx_c < NXW'(NATIVE_WIDTH)) nx_d = nx_c + 1'b1;
      end else begin
        px_d = px_c + 2'd1;
      end
    end else if (de_q && !vs_rise) begin
      px_d = 2'd0;
      nx_d = '0;
      if (py_c == LAST_PHASE) begin
        py_d = 2'd0;
        if (ny_c < NYW'(NATIVE_HEIGHT)) ny_d = ny_c + 1'b1;
      end else begin
        py_d = py_c + 2'd1;
      end
    end
  end

  assign take = de_in && (nx_c < NXW'(NATIVE_WIDTH)) && (ny_c < NYW'(NATIVE_HEIGHT));

`ifdef VIDEO_DOWNSCALER_BOX_FILTER_EN
  logic [2:0][HW-1:0]   hsum_full;
  logic [2:0][ACCW-1:0] acc_sum;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      hsum_full[c] = hsum_q[c] + HW'(pix[c]);
      acc_sum[c]   = rd_data[c] + ACCW'(hsum_full[c]);
    end
  end
`endif

  always_comb begin
    hsum_d     = hsum_q;
    total_d    = total_q;
    wr_data    = '0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    s1_valid_d = 1'b0;
    if (take) begin
      case (px_c)
        2'd0: for (int c = 0; c < 3; c++) hsum_d[c] = HW'(pix[c]);
        2'd1: begin
          rd_en = 1'b1;
`ifdef VIDEO_DOWNSCALER_BOX_FILTER_EN
          hsum_d = hsum_full;
`endif
        end
        2'd2: begin
          s1_valid_d = (py_c == LAST_PHASE);
`ifdef VIDEO_DOWNSCALER_BOX_FILTER_EN
          wr_en = (py_c != LAST_PHASE);
          for (int c = 0; c < 3; c++) begin
            wr_data[c] = (py_c == 2'd0) ? ACCW'(hsum_full[c]) : acc_sum[c];
          end
          if (s1_valid_d) total_d = acc_sum;
`else
          // Top-left pixel of the block was held in hsum_q since phase 0.
          wr_en   = (py_c == 2'd0);
          wr_data = hsum_q;
          if (s1_valid_d) total_d = rd_data;
`endif
        end
        default: ;
      endcase
    end
  end

  video_box3_line_acc #(
    .DEPTH(NATIVE_WIDTH),
    .WIDTH(3 * ACCW)
  ) u_line_acc (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(nx_c[XW-1:0]),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(nx_c[XW-1:0]),
    .rd_data(rd_data)
  );

  always_comb begin
    for (int c = 0; c < 3; c++) begin
`ifdef VIDEO_DOWNSCALER_BOX_FILTER_EN
      res[c] = div9(total_q[c]);
`else
      res[c] = total_q[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q       <= 1'b0;
      vs_q1      <= 1'b0;
      vs_q2      <= 1'b0;
      hs_q1      <= 1'b0;
      hs_q2      <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      hsum_q     <= '0;
      total_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      de_q       <= de_in;
      vs_q1      <= vs_in;
      vs_q2      <= vs_q1;
      hs_q1      <= hs_in;
      hs_q2      <= hs_q1;
      px_q       <= px_d;
      py_q       <= py_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      hsum_q     <= hsum_d;
      total_q    <= total_d;
      s1_valid_q <= s1_valid_d;
      if (s1_valid_d) begin
        s1_x_q <= nx_c[XW-1:0];
        s1_y_q <= ny_c[YW-1:0];
      end
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= rgb_t'(res);
        x_q   <= s1_x_q;
        y_q   <= s1_y_q;
      end
    end
  end

  assign r_out     = out_q.r;
  assign g_out     = out_q.g;
  assign b_out     = out_q.b;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign valid_out = valid_q;
  assign hs_out    = hs_q2;
  assign vs_out    = vs_q2;

endmodule

// File: tb/tb_video_downscaler_3x.sv
// Bench for video_downscaler_3x on a reduced 8x4 native raster (24x12 scaled).
module tb_video_downscaler_3x;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
  localparam int LINE = 3 * W;
`ifdef VIDEO_DOWNSCALER_BOX_FILTER_EN
  localparam bit BOX = 1'b1;
  localparam int EXP_HOT_R = 28;
`else
  localparam bit BOX = 1'b0;
  localparam int EXP_HOT_R = 255;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] r_in, g_in, b_in;
  logic hs_in, vs_in, de_in;
  logic [7:0] r_out, g_out, b_out;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic valid_out, hs_out, vs_out;

  video_downscaler_3x #(
    .NATIVE_WIDTH (W),
    .NATIVE_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .de_in    (de_in),
    .r_out    (r_out),
    .g_out    (g_out),
    .b_out    (b_out),
    .out_x    (out_x),
    .out_y    (out_y),
    .valid_out(valid_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int rgb;
    int cyc;
  } strobe_t;

  typedef struct {
    logic [23:0] in_rgb;
    logic [23:0] exp_rgb;
  } flat_vec_t;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  strobe_t exp_q[$];
  strobe_t obs_q[$];

  // Reference model state: the current frame's pixels as driven.
  logic [23:0] fr [16][32];
  int line_cnt;
  int pix_cyc [32];
  int pat_mode;
  logic [23:0] pat_val;

  int sync_err = 0, hold_err = 0, mon_arm = 0;
  logic hs_h1 = 0, hs_h2 = 0, vs_h1 = 0, vs_h2 = 0;
  logic [23:0] last_rgb = '0;
  int last_x = 0, last_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    strobe_t s;
    if (!rst_n) begin
      mon_arm <= 0;
    end else begin
      if (mon_arm >= 2 && (hs_out !== hs_h2 || vs_out !== vs_h2)) sync_err <= sync_err + 1;
      if (mon_arm < 2) mon_arm <= mon_arm + 1;
      if (!valid_out && ({r_out, g_out, b_out} !== last_rgb || int'(out_x) != last_x ||
                         int'(out_y) != last_y)) hold_err <= hold_err + 1;
    end
    if (valid_out) begin
      s.x = int'(out_x); s.y = int'(out_y); s.rgb = int'({r_out, g_out, b_out}); s.cyc = cyc;
      obs_q.push_back(s);
    end
    hs_h2 <= hs_h1; hs_h1 <= hs_in;
    vs_h2 <= vs_h1; vs_h1 <= vs_in;
    last_rgb <= {r_out, g_out, b_out};
    last_x <= int'(out_x);
    last_y <= int'(out_y);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [23:0] gen_pix(input int l, input int c);
    case (pat_mode)
      0: return pat_val;
      1: return (l == 0 && c == 0) ? 24'hFF0000 : 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  // On each line end: the third line of a block row yields one pixel per complete column.
  task automatic model_line_end(input int len);
    strobe_t e;
    int nb, s;
    logic [23:0] v;
    if (line_cnt % 3 == 2 && line_cnt / 3 < int'(H)) begin
      nb = len / 3;
      if (nb > int'(W)) nb = W;
      for (int bx = 0; bx < nb; bx++) begin
        e.x = bx; e.y = line_cnt / 3; e.cyc = pix_cyc[3 * bx + 2] + 2;
        if (BOX) begin
          for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int dy = 0; dy < 3; dy++)
              for (int dx = 0; dx < 3; dx++) s += int'(fr[line_cnt - 2 + dy][3 * bx + dx][8 * ch +: 8]);
            v[8 * ch +: 8] = 8'((s * 7282) >> 16);
          end
        end else begin
          v = fr[line_cnt - 2][3 * bx];
        end
        e.rgb = int'(v);
        exp_q.push_back(e);
      end
    end
    line_cnt++;
  endtask

  task automatic drive_line(input int len, input bit vs_first);
    logic [23:0] px;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      de_in = 1'b0; hs_in = (i < 2);
    end
    if (vs_first) line_cnt = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      de_in = 1'b1; hs_in = 1'b0;
      if (vs_first) vs_in = 1'b1;
      px = gen_pix(line_cnt, i);
      {r_in, g_in, b_in} = px;
      if (line_cnt < 16 && i < 32) begin
        fr[line_cnt][i] = px;
        pix_cyc[i] = cyc;
      end
    end
    @(posedge clk); #1;
    de_in = 1'b0; vs_in = 1'b0;
    model_line_end(len);
  endtask

  task automatic start_frame();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      de_in = 1'b0; vs_in = (i < 3);
    end
    line_cnt = 0;
  endtask

  task automatic frame(input int nlines, input int len);
    start_frame();
    for (int l = 0; l < nlines; l++) drive_line(len, 1'b0);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic compare_queues(input string name);
    int n;
    check($sformatf("%s.count", name), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].x", name, i), obs_q[i].x, exp_q[i].x);
      check($sformatf("%s[%0d].y", name, i), obs_q[i].y, exp_q[i].y);
      check($sformatf("%s[%0d].rgb", name, i), obs_q[i].rgb, exp_q[i].rgb);
      check($sformatf("%s[%0d].cycle", name, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".valid"}, int'(valid_out), 0);
    check({name, ".rgb"}, int'({r_out, g_out, b_out}), 0);
    check({name, ".xy"}, int'({out_x, out_y}), 0);
    check({name, ".syncs"}, int'({hs_out, vs_out}), 0);
  endtask

  initial begin
    flat_vec_t tbl [4];
    tbl[0] = '{in_rgb: 24'h4080C0, exp_rgb: 24'h4080C0};
    tbl[1] = '{in_rgb: 24'hFFFFFF, exp_rgb: 24'hFFFFFF};
    tbl[2] = '{in_rgb: 24'h000000, exp_rgb: 24'h000000};
    tbl[3] = '{in_rgb: 24'h112233, exp_rgb: 24'h112233};

    rst_n = 1'b0; {r_in, g_in, b_in} = '0; hs_in = 0; vs_in = 0; de_in = 0;
    line_cnt = 0; pat_mode = 0; pat_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Flat frames: every strobe carries the flat value, in raster order.
    for (int t = 0; t < 4; t++) begin
      pat_mode = 0; pat_val = tbl[t].in_rgb;
      frame(3 * H, LINE);
      drain();
      check($sformatf("flat%0d.strobes", t), obs_q.size(), W * H);
      for (int i = 0; i < obs_q.size(); i++) begin
        check($sformatf("flat%0d[%0d].rgb", t, i), obs_q[i].rgb, int'(tbl[t].exp_rgb));
        check($sformatf("flat%0d[%0d].x", t, i), obs_q[i].x, i % W);
        check($sformatf("flat%0d[%0d].y", t, i), obs_q[i].y, i / W);
      end
      compare_queues($sformatf("flat%0d", t));
    end

    // Single hot top-left pixel in block (0,0).
    pat_mode = 1;
    frame(3, LINE);
    drain();
    if (obs_q.size() > 0) begin
      check("hot.r", int'(obs_q[0].rgb[23:16]), EXP_HOT_R);
      check("hot.gb", int'(obs_q[0].rgb[15:0]), 0);
    end else begin
      check("hot.present", 0, 1);
    end
    compare_queues("hot");

    // 7-pixel lines: the trailing pixel's column never completes.
    pat_mode = 2;
    frame(3, 7);
    drain();
    check("short.strobes", obs_q.size(), 2);
    compare_queues("short");

    for (int t = 0; t < 3; t++) begin
      pat_mode = 2;
      frame(3 * H, LINE);
      drain();
      compare_queues($sformatf("rand%0d", t));
    end

    // Reset in the middle of a frame, inside a partial block.
    pat_mode = 2;
    frame(4, LINE);
    drain();
    compare_queues("pre_reset");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      de_in = 1'b1; {r_in, g_in, b_in} = 24'($urandom);
    end
    @(posedge clk); #1;
    de_in = 1'b0; rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pat_mode = 0; pat_val = 24'h111111;
    frame(3 * H, LINE);
    drain();
    if (obs_q.size() > 0) check("post_reset.first_xy", obs_q[0].x + obs_q[0].y, 0);
    else check("post_reset.present", 0, 1);
    compare_queues("post_reset");

    // New vs rise after 4 lines, coincident with the first pixel of the new frame.
    pat_mode = 2;
    frame(4, LINE);
    pat_mode = 0; pat_val = 24'h5A3C96;
    drive_line(LINE, 1'b1);
    drive_line(LINE, 1'b0);
    drive_line(LINE, 1'b0);
    drain();
    check("vs_restart.strobes", obs_q.size(), 2 * W);
    if (obs_q.size() > W) begin
      check("vs_restart.xy", obs_q[W].x + obs_q[W].y, 0);
      check("vs_restart.rgb", obs_q[W].rgb, 32'h5A3C96);
    end
    compare_queues("vs_restart");

    check("sync_delay_errors", sync_err, 0);
    check("hold_errors", hold_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
